pipe_stall_ctrl: RTL

Central stall/flush controller for the 5-stage pipeline. It arbitrates hazard requests from ID (load-use), EX (multi-cycle ops) and MEM (bus wait), plus exceptions from MEM. It drives the 6-bit `stall` vector that every pipeline register (pc_reg, if_id, id_ex, ex_mem, mem_wb) consumes, and it issues a registered flush pulse with a redirect PC. It also sequences multi-cycle EX operations with a watchdog counter.

---
 rtl/pipe_stall_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: arbitrates ID/EX/MEM hazards, sequences
// multi-cycle EX ops under a watchdog, and issues a registered flush/redirect.
module pipe_stall_ctrl #(
  parameter int MC_MAX = 40,
  parameter int CNT_W  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        ex_mc_start,
  input  logic        ex_mc_done,
  input  logic        mem_req,
  input  logic        mem_ack,
  input  logic        excpt,
  input  logic [31:0] excpt_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        mc_timeout
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    EX_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MC_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              timeout_reg, timeout_next;
  logic              flush_reg;
  logic [31:0]       new_pc_reg;
  logic              ex_hold;

  assign ex_hold = ((state_reg == RUN) && ex_mc_start && !ex_mc_done) ||
                   ((state_reg == EX_WAIT) && !ex_mc_done);

  // Stall vector; reset forces all-run regardless of requests.
  always_comb begin
    stall = 6'b000000;
    if (!rst || excpt || (state_reg == FLUSH)) begin
      stall = 6'b000000;
    end else if (mem_req && !mem_ack) begin
      stall = 6'b011111;
    end else if (ex_hold) begin
      stall = 6'b001111;
    end else if (stallreq_id) begin
      stall = 6'b000111;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    timeout_next = timeout_reg;
    case (state_reg)
      RUN: begin
        if (excpt) begin
          state_next = FLUSH;
        end else if (ex_mc_start && !ex_mc_done) begin
          state_next = EX_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      EX_WAIT: begin
        if (excpt) begin
          state_next = FLUSH;
          cnt_next   = '0;
        end else if (ex_mc_done) begin
          state_next = RUN;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LIMIT) begin
          state_next   = RUN;
          timeout_next = 1'b1;
          cnt_next     = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      FLUSH: begin
        // A new multi-cycle start here is dropped; only excpt extends FLUSH.
        state_next = excpt ? FLUSH : RUN;
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= RUN;
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
      flush_reg   <= 1'b0;
      new_pc_reg  <= 32'h0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
      flush_reg   <= excpt;
      if (excpt) begin
        new_pc_reg <= excpt_pc;
      end
    end
  end

  assign flush      = flush_reg;
  assign new_pc     = new_pc_reg;
  assign mc_timeout = timeout_reg;

endmodule
